// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared encodings for the RV32I decode/ALU/data-memory slice
// No ports. Holds the ALU_*, RS1_*, RS2_*, WB_*, BR_* encodings, the opcodes,
// and funct3 -> alu_fn / br mapping helpers.
package rv32i_pkg;
    localparam logic [4:0] ALU_X    = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_JALR = 5'd11;

    localparam logic [1:0] RS1_X   = 2'd0;
    localparam logic [1:0] RS1_RS1 = 2'd1;
    localparam logic [1:0] RS1_PC  = 2'd2;

    localparam logic [1:0] RS2_X   = 2'd0;
    localparam logic [1:0] RS2_RS2 = 2'd1;
    localparam logic [1:0] RS2_IMI = 2'd2;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [2:0] BR_X    = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JAL  = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    // alt selects SUB over ADD (funct3 000) and SRA over SRL (funct3 101)
    function automatic logic [4:0] alu_fn_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // funct3 010/011 are not branches and map to BR_X
    function automatic logic [2:0] br_of(input logic [2:0] f3);
        case (f3)
            3'b000:  return BR_BEQ;
            3'b001:  return BR_BNE;
            3'b100:  return BR_BLT;
            3'b101:  return BR_BGE;
            3'b110:  return BR_BLTU;
            3'b111:  return BR_BGEU;
            default: return BR_X;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_alu.sv
// rv32i_alu: combinational 32-bit RV32I ALU
// Ports: fn [4:0] op code (ALU_*), src1/src2 [31:0] operands, alu_out [31:0] result.
// Shifts use src2[4:0]; unused op codes give 0.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [4:0]  fn,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] alu_out
);
    logic [31:0] sum;
    logic [4:0]  sh;

    assign sum = src1 + src2;
    assign sh  = src2[4:0];

    always_comb begin
        alu_out = '0;
        case (fn)
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = src1 - src2;
            ALU_AND:  alu_out = src1 & src2;
            ALU_OR:   alu_out = src1 | src2;
            ALU_XOR:  alu_out = src1 ^ src2;
            ALU_SLL:  alu_out = src1 << sh;
            ALU_SRL:  alu_out = src1 >> sh;
            ALU_SRA:  alu_out = $unsigned($signed(src1) >>> sh);
            ALU_SLT:  alu_out = {31'd0, $signed(src1) < $signed(src2)};
            ALU_SLTU: alu_out = {31'd0, src1 < src2};
            ALU_JALR: alu_out = sum & ~32'd1;
            default:  alu_out = '0;
        endcase
    end
endmodule

// File: rtl/rv32i_dec_alu_dmem.sv
// rv32i_dec_alu_dmem: RV32I decoder, ALU and word data memory slice
module rv32i_dec_alu_dmem
  import rv32i_pkg::*;
#(
  parameter int DMEM_AW   = 8,
  parameter     INIT_FILE = "dmem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [4:0]  alu_fn,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic        mem_wen,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br,
  output logic        ecall,
  input  logic [4:0]  fn,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] alu_out,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);
  localparam int DEPTH = 1 << DMEM_AW;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        shift_imm;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shift_imm = f3 == 3'b001 || f3 == 3'b101;
  always_comb begin
    imm      = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    alu_fn   = ALU_X;
    rs1_sel  = RS1_X;
    rs2_sel  = RS2_X;
    mem_wen  = 1'b0;
    wb_sel   = WB_X;
    br       = BR_X;
    ecall    = 1'b0;
    case (opc)
      OPC_LOAD: begin
        alu_fn = ALU_ADD; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI;
        imm = imm_i; rs1_addr = inst[19:15]; wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        alu_fn = ALU_ADD; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI;
        imm = imm_s; rs1_addr = inst[19:15]; rs2_addr = inst[24:20]; mem_wen = 1'b1;
      end
      OPC_OP: begin
        alu_fn = alu_fn_of(f3, inst[30]); rs1_sel = RS1_RS1; rs2_sel = RS2_RS2;
        rs1_addr = inst[19:15]; rs2_addr = inst[24:20]; wb_sel = WB_ALU;
      end
      OPC_OP_IMM: begin
        alu_fn = alu_fn_of(f3, f3 == 3'b101 && inst[30]); rs1_sel = RS1_RS1; rs2_sel = RS2_IMI;
        imm = shift_imm ? {27'd0, inst[24:20]} : imm_i;
        rs1_addr = inst[19:15]; wb_sel = WB_ALU;
      end
      OPC_BRANCH: begin
        alu_fn = ALU_ADD; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; imm = imm_b;
        br = br_of(f3); rs1_addr = inst[19:15]; rs2_addr = inst[24:20];
      end
      OPC_JAL: begin
        alu_fn = ALU_ADD; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; imm = imm_j;
        wb_sel = WB_PC; br = BR_JAL;
      end
      OPC_JALR: begin
        alu_fn = ALU_JALR; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI; imm = imm_i;
        rs1_addr = inst[19:15]; wb_sel = WB_PC; br = BR_JAL;
      end
      OPC_LUI: begin
        alu_fn = ALU_ADD; rs2_sel = RS2_IMI; imm = imm_u; wb_sel = WB_ALU;
      end
      OPC_AUIPC: begin
        alu_fn = ALU_ADD; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; imm = imm_u; wb_sel = WB_ALU;
      end
      OPC_SYSTEM: ecall = inst == ECALL_INST;
      default: ;
    endcase
  end
  assign rd_addr = wb_sel == WB_X ? 5'd0 : inst[11:7];
  rv32i_alu u_alu (
    .fn      (fn),
    .src1    (src1),
    .src2    (src2),
    .alu_out (alu_out)
  );
  logic [31:0]        mem [DEPTH];
  logic [DMEM_AW-1:0] widx;
  logic               unused_addr;
  assign widx          = mem_addr[DMEM_AW+1:2];
  assign unused_addr   = ^{mem_addr[31:DMEM_AW+2], mem_addr[1:0]};
  assign mem_read_data = mem[widx];
`ifdef DMEM_INIT_EN
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always_ff @(posedge clk) begin
    if (!reset && mem_write_en) mem[widx] <= mem_write_data;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write_en) begin
      mem[widx] <= mem_write_data;
    end
  end
`endif
endmodule

// File: tb/tb_rv32i_dec_alu_dmem.sv
// tb_rv32i_dec_alu_dmem: directed self-checking bench for rv32i_dec_alu_dmem
module tb_rv32i_dec_alu_dmem;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, alu_fn;
    logic [1:0]  rs1_sel, rs2_sel, wb_sel;
    logic        mem_wen, ecall;
    logic [2:0]  br;
    logic [4:0]  fn;
    logic [31:0] src1, src2, alu_out;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_dec_alu_dmem dut (
        .clk            (clk),
        .reset          (reset),
        .inst           (inst),
        .imm            (imm),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rd_addr        (rd_addr),
        .alu_fn         (alu_fn),
        .rs1_sel        (rs1_sel),
        .rs2_sel        (rs2_sel),
        .mem_wen        (mem_wen),
        .wb_sel         (wb_sel),
        .br             (br),
        .ecall          (ecall),
        .fn             (fn),
        .src1           (src1),
        .src2           (src2),
        .alu_out        (alu_out),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {alu_fn, rs1_sel, rs2_sel, wb_sel, br, mem_wen, ecall}
    function automatic logic [15:0] ctl();
        return {alu_fn, rs1_sel, rs2_sel, wb_sel, br, mem_wen, ecall};
    endfunction

    // {rs1_addr, rs2_addr, rd_addr}
    function automatic logic [14:0] regs();
        return {rs1_addr, rs2_addr, rd_addr};
    endfunction

    task automatic dec(input logic [31:0] i);
        inst = i;
        #1;
    endtask

    task automatic alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        fn = f; src1 = a; src2 = b;
        #1;
    endtask

    initial begin
        reset = 1'b1; inst = '0; fn = '0; src1 = '0; src2 = '0;
        mem_write_en = 1'b0; mem_addr = 32'h10; mem_write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 check("reset_mem", mem_read_data, 32'h0);

        dec(32'h0000_0000);
        check("bubble_all", {imm, regs(), ctl()}, 64'h0);
        dec(32'h0000_0073);
        check("ecall_ctl", {imm, regs(), ctl()}, 64'h1);

        dec(32'h0020_81B3);
        check("add_ctl",  ctl(),  {5'd1, 2'd1, 2'd1, 2'd1, 3'd0, 1'b0, 1'b0});
        check("add_regs", regs(), {5'd1, 5'd2, 5'd3});
        dec(32'h4020_81B3);
        check("sub_fn",   alu_fn, 5'd2);

        dec(32'h0020_A423);
        check("sw_imm",   imm,    32'd8);
        check("sw_ctl",   ctl(),  {5'd1, 2'd1, 2'd2, 2'd0, 3'd0, 1'b1, 1'b0});
        check("sw_regs",  regs(), {5'd1, 5'd2, 5'd0});

        dec(32'hFFF0_0293);
        check("addi_imm", imm,    32'hFFFF_FFFF);
        check("addi_ctl", ctl(),  {5'd1, 2'd1, 2'd2, 2'd1, 3'd0, 1'b0, 1'b0});
        dec(32'h4031_5093);
        check("srai_imm", imm,    32'd3);
        check("srai_fn",  alu_fn, 5'd8);
        dec(32'h0000_2283);
        check("lw_ctl",   ctl(),  {5'd1, 2'd1, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0});
        dec(32'hFE20_8EE3);
        check("beq_imm",  imm,    32'hFFFF_FFFC);
        check("beq_ctl",  ctl(),  {5'd1, 2'd2, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0});
        check("beq_regs", regs(), {5'd1, 5'd2, 5'd0});
        dec(32'h0080_00EF);
        check("jal_imm",  imm,    32'd8);
        check("jal_ctl",  ctl(),  {5'd1, 2'd2, 2'd2, 2'd3, 3'd7, 1'b0, 1'b0});
        dec(32'h0040_80E7);
        check("jalr_ctl", ctl(),  {5'd11, 2'd1, 2'd2, 2'd3, 3'd7, 1'b0, 1'b0});
        dec(32'h1234_50B7);
        check("lui_imm",  imm,    32'h1234_5000);
        check("lui_ctl",  ctl(),  {5'd1, 2'd0, 2'd2, 2'd1, 3'd0, 1'b0, 1'b0});
        dec(32'h0000_007F);
        check("bad_opc",  {imm, regs(), ctl()}, 64'h0);

        alu(5'd8,  32'h8000_0000, 32'd4);
        check("alu_sra",  alu_out, 32'hF800_0000);
        alu(5'd9,  32'hFFFF_FFFF, 32'd1);
        check("alu_slt",  alu_out, 32'd1);
        alu(5'd10, 32'hFFFF_FFFF, 32'd1);
        check("alu_sltu", alu_out, 32'd0);
        alu(5'd11, 32'h103, 32'd0);
        check("alu_jalr", alu_out, 32'h102);
        alu(5'd2,  32'd5, 32'd7);
        check("alu_sub",  alu_out, 32'hFFFF_FFFE);
        alu(5'd6,  32'd1, 32'd33);
        check("alu_sll",  alu_out, 32'd2);
        alu(5'd7,  32'h8000_0000, 32'd31);
        check("alu_srl",  alu_out, 32'd1);
        alu(5'd1,  32'hFFFF_FFFF, 32'd2);
        check("alu_addwrap", alu_out, 32'd1);
        alu(5'd5,  32'hF0F0_F0F0, 32'hFFFF_0000);
        check("alu_xor",  alu_out, 32'h0F0F_F0F0);
        alu(5'd12, 32'h1234, 32'h5678);
        check("alu_fn12", alu_out, 32'd0);

        @(negedge clk);
        mem_write_en = 1'b1; mem_addr = 32'h10; mem_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_write_en = 1'b0;
        #1 check("mem_rd10", mem_read_data, 32'hDEAD_BEEF);
        mem_addr = 32'h13;
        #1 check("mem_rd13", mem_read_data, 32'hDEAD_BEEF);
        mem_addr = 32'h410;
        #1 check("mem_wrap", mem_read_data, 32'hDEAD_BEEF);
        mem_addr = 32'h14;
        #1 check("mem_other", mem_read_data, 32'h0);

        @(negedge clk);
        mem_write_en = 1'b1; mem_addr = 32'h10; mem_write_data = 32'h1234_5678;
        #1 check("mem_rdold", mem_read_data, 32'hDEAD_BEEF);
        @(negedge clk);
        mem_write_en = 1'b0;
        #1 check("mem_rdnew", mem_read_data, 32'h1234_5678);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        #1 check("mem_rst_clr", mem_read_data, 32'h0);

        @(negedge clk);
        reset = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h20; mem_write_data = 32'h5555_AAAA;
        @(negedge clk);
        reset = 1'b0; mem_write_en = 1'b0;
        #1 check("mem_rst_nowr", mem_read_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
